nx_ia_mem_port_arb: RTL

// - Sits directly downstream of the indirect-access controller. Consumes its sw_* memory strobes, returns sw_rdat/sw_match/sw_aindex and drives its grant input.
// - Arbitrates between the software indirect-access port and a hardware datapath port for one single-port table RAM (1-cycle read latency).
// - Implements the compare operation: reads one entry and reports the full-word match and the first differing nibble.

---
 rtl/nx_ia_mem_port_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nx_ia_mem_port_arb.sv
// Table RAM port arbiter between the SW indirect-access controller and the HW datapath, with compare support.
// Optional statistics counters are enabled by defining NX_IA_ARB_STATS_EN.
module nx_ia_mem_port_arb #(
    parameter int N_ENTRIES     = 32,
    parameter int N_ADDR_BITS   = 5,
    parameter int N_DATA_BITS   = 64,
    parameter int N_STARVE_BITS = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sw_cs_i,
    input  logic                   sw_ce_i,
    input  logic                   sw_we_i,
    input  logic [N_ADDR_BITS-1:0] sw_add_i,
    input  logic [N_DATA_BITS-1:0] sw_wdat_i,
    output logic                   grant_o,
    input  logic                   yield_i,
    output logic [N_DATA_BITS-1:0] sw_rdat_o,
    output logic                   sw_match_o,
    output logic [3:0]             sw_aindex_o,
    input  logic                   hw_req_i,
    input  logic                   hw_we_i,
    input  logic [N_ADDR_BITS-1:0] hw_add_i,
    input  logic [N_DATA_BITS-1:0] hw_wdat_i,
    output logic                   hw_gnt_o,
    output logic [N_DATA_BITS-1:0] hw_rdat_o,
    output logic                   hw_rvld_o,
    output logic                   mem_cs_o,
    output logic                   mem_we_o,
    output logic [N_ADDR_BITS-1:0] mem_add_o,
    output logic [N_DATA_BITS-1:0] mem_wdat_o,
`ifdef NX_IA_ARB_STATS_EN
    input  logic                   stat_clr_i,
    output logic [15:0]            stat_sw_stall_o,
    output logic [15:0]            stat_hw_gnt_o,
`endif
    input  logic [N_DATA_BITS-1:0] mem_rdat_i
);

    localparam int N_NIBBLES = N_DATA_BITS / 4;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_HW_RD  = 2'd1;
    localparam logic [1:0] OWN_SW_RD  = 2'd2;
    localparam logic [1:0] OWN_SW_CMP = 2'd3;

    localparam logic [N_STARVE_BITS-1:0] STARVE_MAX = '1;
    localparam logic [N_STARVE_BITS-1:0] STARVE_ONE = 1;

    if (N_ENTRIES > (1 << N_ADDR_BITS) || (N_DATA_BITS % 4) != 0 || N_NIBBLES > 16) begin : g_bad_cfg
        $error("nx_ia_mem_port_arb: inconsistent parameters");
    end

    logic [1:0]               owner_q, owner_d;
    logic [N_STARVE_BITS-1:0] starve_cnt_q, starve_cnt_d;
    logic                     starve_hit;
    logic [N_DATA_BITS-1:0]   key_q;
    logic [N_DATA_BITS-1:0]   sw_rdat_q;
    logic                     sw_match_q;
    logic [3:0]               sw_aindex_q, sw_aindex_d;
    logic [N_DATA_BITS-1:0]   hw_rdat_q;
    logic                     hw_rvld_q;
    logic [N_DATA_BITS-1:0]   diff;

    // Grants are qualified by reset so nothing reaches the RAM while rst_i is high.
    always_comb begin
        starve_hit = (starve_cnt_q == STARVE_MAX);
        grant_o    = !rst_i && sw_cs_i && (!hw_req_i || yield_i || starve_hit);
        hw_gnt_o   = !rst_i && hw_req_i && !grant_o;
    end

    always_comb begin
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_add_o  = '0;
        mem_wdat_o = '0;
        owner_d    = OWN_NONE;
        if (grant_o) begin
            mem_cs_o   = 1'b1;
            mem_we_o   = sw_we_i;
            mem_add_o  = sw_add_i;
            mem_wdat_o = sw_wdat_i;
            if (!sw_we_i) owner_d = sw_ce_i ? OWN_SW_CMP : OWN_SW_RD;
        end else if (hw_gnt_o) begin
            mem_cs_o   = 1'b1;
            mem_we_o   = hw_we_i;
            mem_add_o  = hw_add_i;
            mem_wdat_o = hw_wdat_i;
            if (!hw_we_i) owner_d = OWN_HW_RD;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!sw_cs_i || grant_o) starve_cnt_d = '0;
        else if (!starve_hit)    starve_cnt_d = starve_cnt_q + STARVE_ONE;
    end

    // Scan from the top so the lowest differing nibble wins.
    always_comb begin
        diff        = mem_rdat_i ^ key_q;
        sw_aindex_d = 4'd0;
        for (int n = N_NIBBLES - 1; n >= 0; n--) begin
            if (|diff[4*n +: 4]) sw_aindex_d = 4'(n);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            key_q        <= '0;
            sw_rdat_q    <= '0;
            sw_match_q   <= 1'b0;
            sw_aindex_q  <= 4'd0;
            hw_rdat_q    <= '0;
            hw_rvld_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            hw_rvld_q    <= (owner_q == OWN_HW_RD);
            if (owner_d == OWN_SW_CMP) key_q <= sw_wdat_i;
            if (owner_q == OWN_SW_RD) sw_rdat_q <= mem_rdat_i;
            if (owner_q == OWN_HW_RD) hw_rdat_q <= mem_rdat_i;
            if (owner_q == OWN_SW_CMP) begin
                sw_match_q  <= ~|diff;
                sw_aindex_q <= sw_aindex_d;
            end
        end
    end

    // SW read data bypasses the holding register in the return cycle.
    assign sw_rdat_o   = (owner_q == OWN_SW_RD) ? mem_rdat_i : sw_rdat_q;
    assign sw_match_o  = sw_match_q;
    assign sw_aindex_o = sw_aindex_q;
    assign hw_rdat_o   = hw_rdat_q;
    assign hw_rvld_o   = hw_rvld_q;

`ifdef NX_IA_ARB_STATS_EN
    logic [15:0] stat_sw_stall_q;
    logic [15:0] stat_hw_gnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_sw_stall_q <= 16'd0;
            stat_hw_gnt_q   <= 16'd0;
        end else if (stat_clr_i) begin
            stat_sw_stall_q <= 16'd0;
            stat_hw_gnt_q   <= 16'd0;
        end else begin
            if (sw_cs_i && !grant_o && !(&stat_sw_stall_q)) stat_sw_stall_q <= stat_sw_stall_q + 16'd1;
            if (hw_gnt_o && !(&stat_hw_gnt_q))              stat_hw_gnt_q   <= stat_hw_gnt_q + 16'd1;
        end
    end

    assign stat_sw_stall_o = stat_sw_stall_q;
    assign stat_hw_gnt_o   = stat_hw_gnt_q;
`endif

endmodule
